pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the fetch stage: a successor to the basic stall-able PC register. It holds the fetch address, advances sequentially, and accepts a resolved redirect from execute. It also implements a small return-address stack (RAS) so calls and returns are handled in fetch without waiting for execute. It drives the instruction-memory address and supplies PC+1 to the fetch/decode pipeline register.

## Interface
Parameters:
- PC_WIDTH, 16, width of PC and all address ports
- RESET_VECTOR, 16'h0000, PC value loaded on reset
- RAS_DEPTH, 4, number of RAS entries (power of two, 2..16)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- Fstall  input  1  fetch stall from hazard unit
- redirect  input  1  taken branch/jump resolved in execute
- redirect_target  input  PC_WIDTH  target for redirect and call
- call  input  1  fetch-stage predecoded call
- ret  input  1  fetch-stage predecoded return
- pcout  output  PC_WIDTH  current fetch address (registered)
- pcplus1  output  PC_WIDTH  pcout+1, combinational, modulo 2^PC_WIDTH
- ras_empty  output  1  RAS holds no entries
- ras_full  output  1  RAS holds RAS_DEPTH entries
- ras_overflow  output  1  sticky: a push occurred while full
- ras_underflow  output  1  sticky: a ret occurred while empty

## Operation
- Next-PC priority, evaluated each cycle:
  - 1. redirect=1: pc <= redirect_target. Overrides Fstall, call and ret. No push or pop.
  - 2. Fstall=1: pc holds. call and ret are ignored; RAS is unchanged.
  - 3. call=1: pc <= redirect_target; push pcplus1. call wins over a simultaneous ret.
  - 4. ret=1 with RAS non-empty: pc <= top entry; pop.
  - 5. ret=1 with RAS empty: pc <= pcplus1; set ras_underflow.
  - 6. Otherwise: pc <= pcplus1.
- Sequential arithmetic wraps: pcout = 2^PC_WIDTH-1 gives pcplus1 = 0.
- RAS is a circular buffer with a top pointer and an occupancy count (0..RAS_DEPTH).
- Push when full overwrites the oldest entry. Count stays RAS_DEPTH and ras_overflow sets. The following RAS_DEPTH pops return the newest RAS_DEPTH pushes in LIFO order.
- ras_overflow and ras_underflow clear only on rst.
- ras_empty = (count==0); ras_full = (count==RAS_DEPTH).

## Timing
- Reset (async, immediate on rst high):
  - pcout=RESET_VECTOR, pcplus1=RESET_VECTOR+1
  - RAS count=0, ras_empty=1, ras_full=0, both sticky flags 0
- Reset asserted mid-operation discards all RAS contents. The first edge after rst falls loads RESET_VECTOR+1 (no other inputs active).
- pcout changes one cycle after the controlling inputs are sampled; no other latency.
- RAS push and pop complete on the same edge that updates pcout. A ret in the cycle after a call returns that call's pcplus1.
- Flag outputs are registered and update on the same edge as the causing event.

## Configuration
- PC_RAS_EN defined: full behaviour above.
- PC_RAS_EN undefined: no RAS storage is built.
  - call behaves as a plain jump to redirect_target.
  - ret is ignored (sequential fetch).
  - ras_empty=1, ras_full=0, and both sticky flags are tied to 0.
  - Fstall and redirect priority are unchanged.

## Test plan
- Reset then 3 idle cycles (RESET_VECTOR=0) -> pcout 0,1,2,3. Assert rst mid-run -> pcout=0 immediately.
- Fstall=1 for 2 cycles at pcout=5 -> pcout stays 5. Fstall=1 with redirect=1 and target 0x40 -> pcout=0x40 next cycle.
- At pcout=0x10: call with target 0x80, then 2 idle cycles, then ret -> pcout 0x80,0x81,0x82,0x11. ras_empty returns to 1.
- RAS_DEPTH=4: 5 calls from pcouts 0x1,0x3,0x5,0x7,0x9 -> ras_overflow=1. Then 4 rets return 0xA,0x8,0x6,0x4. A 5th ret gives sequential fetch and ras_underflow=1.
- Same cycle call=1 and redirect=1 (target 0x20) -> pcout=0x20, no push. Same cycle call=1 and ret=1 -> call taken, no pop.
- PC_WIDTH=16 at pcout=0xFFFF idle -> pcout=0x0000. With PC_RAS_EN undefined, call then ret -> ret fetches target+1 and RAS flags stay 0.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with redirect, stall and an optional
// return-address stack (RAS) for predecoded calls and returns.
//
// Build option: define PC_RAS_EN to build the RAS. When it is undefined:
//   - call is a plain jump
//   - ret is ignored
//   - the RAS flags are constant
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   Fstall            hold the PC (call/ret ignored)
//   redirect          resolved redirect from execute, highest priority
//   redirect_target   target for redirect and call
//   call, ret         predecoded call / return in fetch
//   pcout             registered fetch address
//   pcplus1           pcout + 1 (combinational, wraps)
//   ras_empty         RAS holds no entries
//   ras_full          RAS holds RAS_DEPTH entries
//   ras_overflow      sticky: a push occurred while the RAS was full
//   ras_underflow     sticky: a ret occurred while the RAS was empty
module pc_unit #(
  parameter int unsigned         PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned         RAS_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Fstall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_target,
  input  logic                call,
  input  logic                ret,
  output logic [PC_WIDTH-1:0] pcout,
  output logic [PC_WIDTH-1:0] pcplus1,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_overflow,
  output logic                ras_underflow
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;

`ifdef PC_RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]    top_q, top_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                of_q, of_d;
  logic                uf_q, uf_d;
  logic                push, pop;
`endif

  assign pcout   = pc_q;
  assign pcplus1 = pc_q + PC_WIDTH'(1);

  // Next-PC priority: redirect > stall > call > ret > sequential
  always_comb begin
    pc_d = pcplus1;
`ifdef PC_RAS_EN
    push  = 1'b0;
    pop   = 1'b0;
    top_d = top_q;
    cnt_d = cnt_q;
    of_d  = of_q;
    uf_d  = uf_q;
`endif
    if (redirect) begin
      pc_d = redirect_target;
    end else if (Fstall) begin
      pc_d = pc_q;
    end else if (call) begin
      pc_d = redirect_target;
`ifdef PC_RAS_EN
      push = 1'b1;
`endif
    end else if (ret) begin
`ifdef PC_RAS_EN
      if (cnt_q != '0) begin
        pc_d = ras_mem_q[top_q];
        pop  = 1'b1;
      end else begin
        uf_d = 1'b1;
      end
`else
      // Without a RAS a return degrades to sequential fetch
      pc_d = pcplus1;
`endif
    end

`ifdef PC_RAS_EN
    // Circular buffer: when full, top+1 is the oldest slot, so a push
    // overwrites it and the count saturates
    if (push) begin
      top_d = top_q + PTR_W'(1);
      if (ras_full) begin
        of_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (pop) begin
      top_d = top_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
`endif
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
`ifdef PC_RAS_EN
      top_q <= '0;
      cnt_q <= '0;
      of_q  <= 1'b0;
      uf_q  <= 1'b0;
`endif
    end else begin
      pc_q  <= pc_d;
`ifdef PC_RAS_EN
      top_q <= top_d;
      cnt_q <= cnt_d;
      of_q  <= of_d;
      uf_q  <= uf_d;
`endif
    end
  end

`ifdef PC_RAS_EN
  // RAS storage; contents are only meaningful below the count, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      ras_mem_q[top_d] <= pcplus1;
    end
  end

  assign ras_empty     = (cnt_q == '0);
  assign ras_full      = (cnt_q == CNT_W'(RAS_DEPTH));
  assign ras_overflow  = of_q;
  assign ras_underflow = uf_q;
`else
  assign ras_empty     = 1'b1;
  // Constant 0 for every legal depth
  assign ras_full      = 1'(RAS_DEPTH == 0);
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit. A behavioural model computes each expected
// next pcout when stimulus is driven and pushes it to a scoreboard queue; the
// queue is popped and compared once the DUT has taken the edge.
module tb_pc_unit;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic        rd;
    logic [15:0] tgt;
    logic        st;
    logic        cl;
    logic        rt;
  } stim_t;

  logic        clk, rst, Fstall, redirect, call, ret;
  logic [15:0] redirect_target, pcout, pcplus1;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] exp_q [$];
  logic [15:0] model_pc;
  logic [15:0] model_ras [$];
  logic        m_of, m_uf;

  pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .Fstall         (Fstall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .call           (call),
    .ret            (ret),
    .pcout          (pcout),
    .pcplus1        (pcplus1),
    .ras_empty      (ras_empty),
    .ras_full       (ras_full),
    .ras_overflow   (ras_overflow),
    .ras_underflow  (ras_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] model_flags();
    logic e, f;
    e = (model_ras.size() == 0);
    f = (model_ras.size() == DEPTH);
    return {e, f, m_of, m_uf};
  endfunction

  task automatic model_reset();
    model_pc = 16'h0000;
    model_ras.delete();
    m_of = 1'b0;
    m_uf = 1'b0;
    exp_q.delete();
  endtask

  // Drive one cycle of stimulus, advance the model, push the expected pcout
  task automatic cycle(input stim_t s);
    logic [15:0] nxt;
    nxt = model_pc + 16'd1;
    if (s.rd) begin
      nxt = s.tgt;
    end else if (s.st) begin
      nxt = model_pc;
    end else if (s.cl) begin
      nxt = s.tgt;
`ifdef PC_RAS_EN
      if (model_ras.size() == DEPTH) begin
        void'(model_ras.pop_front());
        m_of = 1'b1;
      end
      model_ras.push_back(model_pc + 16'd1);
`endif
    end else if (s.rt) begin
`ifdef PC_RAS_EN
      if (model_ras.size() > 0) nxt = model_ras.pop_back();
      else m_uf = 1'b1;
`endif
    end
    model_pc = nxt;
    exp_q.push_back(nxt);
    redirect = s.rd; redirect_target = s.tgt; Fstall = s.st; call = s.cl; ret = s.rt;
    @(posedge clk);
    #1;
    redirect = 1'b0; Fstall = 1'b0; call = 1'b0; ret = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    stim_t idle;
    idle = '{1'b0, 16'h0, 1'b0, 1'b0, 1'b0};
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (pcout !== 16'h0000 || pcplus1 !== 16'h0001) begin
      n_bad++;
      $display("FAIL reset_pc pcout=%h pcplus1=%h want 0000/0001", pcout, pcplus1);
    end
    n_cmp++;
    if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 1000", {ras_empty, ras_full, ras_overflow, ras_underflow});
    end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cycle(idle);
      exp = exp_q.pop_front();
      n_cmp++;
      if (pcout !== exp || pcout !== 16'(i)) begin
        n_bad++;
        $display("FAIL reset_idle%0d pcout got %h want %h", i, pcout, exp);
      end
    end
    // Asynchronous reset away from any clock edge
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (pcout !== 16'h0000 || pcplus1 !== 16'h0001) begin
      n_bad++;
      $display("FAIL reset_async pcout=%h pcplus1=%h want 0000/0001", pcout, pcplus1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(idle);
    exp = exp_q.pop_front();
    n_cmp++;
    if (pcout !== exp || pcout !== 16'h0001) begin
      n_bad++;
      $display("FAIL reset_release pcout got %h want %h", pcout, exp);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp, exp_p1;
    stim_t s [4];
    s = '{'{1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0},
          '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0},
          '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0},
          '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      cycle(s[i]);
      exp = exp_q.pop_front();
      exp_p1 = exp + 16'd1;
      n_cmp++;
      if (pcout !== exp) begin
        n_bad++;
        $display("FAIL wrap%0d pcout got %h want %h", i, pcout, exp);
      end
      n_cmp++;
      if (pcplus1 !== exp_p1) begin
        n_bad++;
        $display("FAIL wrap%0d pcplus1 got %h want %h", i, pcplus1, exp_p1);
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] exp;
    logic [15:0] plan [5];
    stim_t s [5];
    plan = '{16'h0005, 16'h0005, 16'h0005, 16'h0040, 16'h0041};
    s = '{'{1'b1, 16'h0005, 1'b0, 1'b0, 1'b0},
          '{1'b0, 16'h0077, 1'b1, 1'b1, 1'b0},
          '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
          '{1'b1, 16'h0040, 1'b1, 1'b0, 1'b0},
          '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      cycle(s[i]);
      exp = exp_q.pop_front();
      n_cmp++;
      if (pcout !== exp || pcout !== plan[i]) begin
        n_bad++;
        $display("FAIL stall%0d pcout got %h want %h", i, pcout, plan[i]);
      end
      n_cmp++;
      if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== model_flags()) begin
        n_bad++;
        $display("FAIL stall%0d flags got %b want %b", i,
                 {ras_empty, ras_full, ras_overflow, ras_underflow}, model_flags());
      end
    end
  endtask

  task automatic test_call_ret();
    logic [15:0] exp;
    stim_t s [5];
    apply_reset();
    s = '{'{1'b1, 16'h0010, 1'b0, 1'b0, 1'b0},
          '{1'b0, 16'h0080, 1'b0, 1'b1, 1'b0},
          '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0},
          '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0},
          '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}};
    for (int i = 0; i < 5; i++) begin
      cycle(s[i]);
      exp = exp_q.pop_front();
      n_cmp++;
      if (pcout !== exp) begin
        n_bad++;
        $display("FAIL call_ret%0d pcout got %h want %h", i, pcout, exp);
      end
      n_cmp++;
      if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== model_flags()) begin
        n_bad++;
        $display("FAIL call_ret%0d flags got %b want %b", i,
                 {ras_empty, ras_full, ras_overflow, ras_underflow}, model_flags());
      end
    end
`ifdef PC_RAS_EN
    n_cmp++;
    if (pcout !== 16'h0011) begin
      n_bad++;
      $display("FAIL call_ret_target pcout got %h want 0011", pcout);
    end
    // Reset mid-operation discards pending RAS entries
    cycle('{1'b0, 16'h0090, 1'b0, 1'b1, 1'b0});
    void'(exp_q.pop_front());
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== 4'b1000) begin
      n_bad++;
      $display("FAIL ras_reset flags got %b want 1000", {ras_empty, ras_full, ras_overflow, ras_underflow});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
`else
    n_cmp++;
    if (pcout !== 16'h0083) begin
      n_bad++;
      $display("FAIL noras_ret pcout got %h want 0083", pcout);
    end
`endif
  endtask

`ifdef PC_RAS_EN
  task automatic test_overflow();
    logic [15:0] exp;
    stim_t s [11];
    apply_reset();
    s = '{'{1'b1, 16'h0001, 1'b0, 1'b0, 1'b0},
          '{1'b0, 16'h0003, 1'b0, 1'b1, 1'b0},
          '{1'b0, 16'h0005, 1'b0, 1'b1, 1'b0},
          '{1'b0, 16'h0007, 1'b0, 1'b1, 1'b0},
          '{1'b0, 16'h0009, 1'b0, 1'b1, 1'b0},
          '{1'b0, 16'h0020, 1'b0, 1'b1, 1'b0},
          '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1},
          '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1},
          '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1},
          '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1},
          '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}};
    for (int i = 0; i < 11; i++) begin
      cycle(s[i]);
      exp = exp_q.pop_front();
      n_cmp++;
      if (pcout !== exp) begin
        n_bad++;
        $display("FAIL overflow%0d pcout got %h want %h", i, pcout, exp);
      end
      n_cmp++;
      if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== model_flags()) begin
        n_bad++;
        $display("FAIL overflow%0d flags got %b want %b", i,
                 {ras_empty, ras_full, ras_overflow, ras_underflow}, model_flags());
      end
    end
    n_cmp++;
    if (pcout !== 16'h0005 || ras_overflow !== 1'b1 || ras_underflow !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_end pcout=%h of=%b uf=%b want 0005/1/1", pcout, ras_overflow, ras_underflow);
    end
  endtask
`endif

  task automatic test_priority();
    logic [15:0] exp;
    stim_t s [7];
    apply_reset();
    s = '{'{1'b1, 16'h0030, 1'b0, 1'b0, 1'b0},
          '{1'b1, 16'h0020, 1'b0, 1'b1, 1'b0},
          '{1'b0, 16'h0060, 1'b0, 1'b1, 1'b1},
          '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1},
          '{1'b0, 16'h0070, 1'b0, 1'b1, 1'b0},
          '{1'b1, 16'h0050, 1'b0, 1'b0, 1'b1},
          '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}};
    for (int i = 0; i < 7; i++) begin
      cycle(s[i]);
      exp = exp_q.pop_front();
      n_cmp++;
      if (pcout !== exp) begin
        n_bad++;
        $display("FAIL priority%0d pcout got %h want %h", i, pcout, exp);
      end
      n_cmp++;
      if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== model_flags()) begin
        n_bad++;
        $display("FAIL priority%0d flags got %b want %b", i,
                 {ras_empty, ras_full, ras_overflow, ras_underflow}, model_flags());
      end
    end
  endtask

  initial begin
    rst = 1'b1; Fstall = 1'b0; redirect = 1'b0; call = 1'b0; ret = 1'b0;
    redirect_target = 16'h0000;
    model_reset();
    test_reset();
    test_wrap();
    test_stall();
    test_call_ret();
`ifdef PC_RAS_EN
    test_overflow();
`endif
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
